// File: rtl/supervisor_trap_csr.sv
`default_nettype none
// ============================================================================
// Module      : supervisor_trap_csr
// Description : S-mode CSR file with WARL masking, vectored stvec, prioritised
//               interrupt selection, trap entry / SRET sequencing and a
//               req/ack TLB-flush handshake towards the MMU. RV32 (Sv32) or
//               RV64 (Sv39) selected by DATA_WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module supervisor_trap_csr #(
  parameter int                    DATA_WIDTH  = 64,
  parameter int                    ASID_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_STVEC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  csr_valid_i,
  input  logic [11:0]           csr_addr_i,
  input  logic [1:0]            csr_op_i,
  input  logic [DATA_WIDTH-1:0] csr_wdata_i,
  output logic                  csr_ready_o,
  output logic [DATA_WIDTH-1:0] csr_rdata_o,
  output logic                  csr_error_o,
  input  logic [1:0]            current_mode_i,
  input  logic                  stip_i,
  input  logic                  seip_i,
  input  logic                  exception_i,
  input  logic [3:0]            exception_code_i,
  input  logic [DATA_WIDTH-1:0] exception_pc_i,
  input  logic [DATA_WIDTH-1:0] exception_tval_i,
  input  logic                  irq_take_i,
  input  logic                  sret_i,
  output logic                  irq_pending_o,
  output logic [3:0]            irq_code_o,
  output logic                  trap_taken_o,
  output logic [DATA_WIDTH-1:0] trap_pc_o,
  output logic [DATA_WIDTH-1:0] return_pc_o,
  output logic [1:0]            return_mode_o,
  output logic [DATA_WIDTH-1:0] satp_o,
  output logic                  sum_o,
  output logic                  mxr_o,
  input  logic                  sfence_valid_i,
  input  logic                  sfence_all_i,
  input  logic [ASID_WIDTH-1:0] sfence_asid_i,
  output logic                  sfence_ready_o,
  output logic                  tlb_flush_req_o,
  output logic                  tlb_flush_all_o,
  output logic [ASID_WIDTH-1:0] tlb_flush_asid_o,
  input  logic                  tlb_flush_ack_i
);

  localparam int c_DW = DATA_WIDTH;

  localparam logic [11:0] c_CSR_SSTATUS  = 12'h100;
  localparam logic [11:0] c_CSR_SIE      = 12'h104;
  localparam logic [11:0] c_CSR_STVEC    = 12'h105;
  localparam logic [11:0] c_CSR_SSCRATCH = 12'h140;
  localparam logic [11:0] c_CSR_SEPC     = 12'h141;
  localparam logic [11:0] c_CSR_SCAUSE   = 12'h142;
  localparam logic [11:0] c_CSR_STVAL    = 12'h143;
  localparam logic [11:0] c_CSR_SIP      = 12'h144;
  localparam logic [11:0] c_CSR_SATP     = 12'h180;

  localparam logic [1:0] c_OP_READ = 2'b00;
  localparam logic [1:0] c_OP_SET  = 2'b10;
  localparam logic [1:0] c_OP_CLR  = 2'b11;

  localparam logic [1:0] c_MODE_U = 2'b00;
  localparam logic [1:0] c_MODE_S = 2'b01;

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_BUSY = 1'b1;

  // SATP field geometry: Sv39 MODE[63:60]/ASID[59:44], Sv32 MODE[31]/ASID[30:22]
  localparam int c_ASID_LSB = (c_DW == 64) ? 44 : 22;
  localparam int c_ASID_MAX = (c_DW == 64) ? 16 : 9;
  localparam int c_MODE_LSB = (c_DW == 64) ? 60 : 31;

  localparam logic [c_DW-1:0] c_ONE        = {{(c_DW-1){1'b0}}, 1'b1};
  localparam logic [c_DW-1:0] c_ALL        = {c_DW{1'b1}};
  localparam logic [c_DW-1:0] c_MODE_MASK  = c_ALL << c_MODE_LSB;
  localparam logic [c_DW-1:0] c_ASID_MASK  = ((c_ONE << ASID_WIDTH) - c_ONE) << c_ASID_LSB;
  localparam logic [c_DW-1:0] c_ASID_UNIMP = ((c_ONE << (c_ASID_MAX - ASID_WIDTH)) - c_ONE)
                                             << (c_ASID_LSB + ASID_WIDTH);
  localparam logic [c_DW-1:0] c_SATP_MASK  = ~c_ASID_UNIMP;

  // Architectural state
  logic                  stat_sie_q, stat_spie_q, stat_spp_q, stat_sum_q, stat_mxr_q;
  logic [2:0]            sie_q;        // {SEIE, STIE, SSIE}
  logic                  ssip_q;
  logic [c_DW-1:2]       stvec_base_q;
  logic [1:0]            stvec_mode_q;
  logic [c_DW-1:0]       sscratch_q, sepc_q, scause_q, stval_q, satp_q;
  logic                  trap_taken_q;
  logic [c_DW-1:0]       trap_pc_q;
  logic [0:0]            state_q, state_d;
  logic                  flush_all_q, flush_all_d;
  logic [ASID_WIDTH-1:0] flush_asid_q, flush_asid_d;

  logic [c_DW-1:0] w_raw, w_new, w_sstatus, w_sip, w_trap_cause;
  logic            w_known, w_error, w_commit, w_busy;
  logic [2:0]      w_en;
  logic            w_irq_enable;
  logic [3:0]      w_irq_code, w_trap_code;
  logic            w_trap, w_trap_irq, w_sret_do;
  logic            w_satp_legal, w_satp_wr, w_mode_chg, w_asid_chg, w_flush_satp;
  logic [c_DW-1:0] w_satp_new;

  assign w_busy = (state_q == c_ST_BUSY);

  // Assemble the masked views of sstatus and sip
  always_comb begin
    w_sstatus     = '0;
    w_sstatus[1]  = stat_sie_q;
    w_sstatus[5]  = stat_spie_q;
    w_sstatus[8]  = stat_spp_q;
    w_sstatus[18] = stat_sum_q;
    w_sstatus[19] = stat_mxr_q;
    w_sip         = '0;
    w_sip[9]      = seip_i;
    w_sip[5]      = stip_i;
    w_sip[1]      = ssip_q;
  end

  // Address decode and pre-update read value of the addressed CSR
  always_comb begin
    w_known = 1'b1;
    w_raw   = '0;
    case (csr_addr_i)
      c_CSR_SSTATUS:  w_raw = w_sstatus;
      c_CSR_SIE: begin
        w_raw[9] = sie_q[2];
        w_raw[5] = sie_q[1];
        w_raw[1] = sie_q[0];
      end
      c_CSR_STVEC:    w_raw = {stvec_base_q, stvec_mode_q};
      c_CSR_SSCRATCH: w_raw = sscratch_q;
      c_CSR_SEPC:     w_raw = sepc_q;
      c_CSR_SCAUSE:   w_raw = scause_q;
      c_CSR_STVAL:    w_raw = stval_q;
      c_CSR_SIP:      w_raw = w_sip;
      c_CSR_SATP:     w_raw = satp_q;
      default:        w_known = 1'b0;
    endcase
  end

  // Read-modify-write operand for write/set/clear
  always_comb begin
    case (csr_op_i)
      c_OP_SET: w_new = w_raw | csr_wdata_i;
      c_OP_CLR: w_new = w_raw & ~csr_wdata_i;
      default:  w_new = csr_wdata_i;
    endcase
  end

  assign w_error     = csr_valid_i & ((current_mode_i == c_MODE_U) | ~w_known);
  assign csr_error_o = w_error;
  assign csr_rdata_o = (csr_valid_i & ~w_error) ? w_raw : '0;
  // Trap/SRET cycles own sstatus & friends; satp is frozen while a flush is outstanding
  assign csr_ready_o = csr_valid_i & ~(exception_i | irq_take_i | sret_i)
                       & ~(w_busy & (csr_addr_i == c_CSR_SATP));
  assign w_commit    = csr_valid_i & csr_ready_o & ~w_error & (csr_op_i != c_OP_READ);

  // Interrupt selection: SEI > SSI > STI
  assign w_en         = {seip_i & sie_q[2], ssip_q & sie_q[0], stip_i & sie_q[1]};
  assign w_irq_enable = (current_mode_i == c_MODE_U) | ((current_mode_i == c_MODE_S) & stat_sie_q);
  assign w_irq_code   = w_en[2] ? 4'd9 : (w_en[1] ? 4'd1 : (w_en[0] ? 4'd5 : 4'd0));
  assign irq_pending_o = w_irq_enable & (|w_en);
  assign irq_code_o    = w_irq_code;

  // Trap arbitration: exception > accepted interrupt > SRET
  assign w_trap_irq   = ~exception_i & irq_take_i & irq_pending_o;
  assign w_trap       = exception_i | w_trap_irq;
  assign w_trap_code  = exception_i ? exception_code_i : w_irq_code;
  assign w_trap_cause = {w_trap_irq, {(c_DW-5){1'b0}}, w_trap_code};
  assign w_sret_do    = sret_i & ~w_trap & (current_mode_i != c_MODE_U);

  // SATP legality depends on the translation scheme
  generate
    if (c_DW == 64) begin : g_sv39
      assign w_satp_legal = (w_new[63:60] == 4'h0) | (w_new[63:60] == 4'h8);
    end else begin : g_sv32
      assign w_satp_legal = 1'b1;
    end
  endgenerate

  assign w_satp_new   = w_new & c_SATP_MASK;
  assign w_satp_wr    = w_commit & (csr_addr_i == c_CSR_SATP) & w_satp_legal;
  assign w_mode_chg   = |((w_satp_new ^ satp_q) & c_MODE_MASK);
  assign w_asid_chg   = |((w_satp_new ^ satp_q) & c_ASID_MASK);
  assign w_flush_satp = w_satp_wr & (w_mode_chg | w_asid_chg);

  // sstatus: trap entry, then SRET, then software writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_sie_q  <= 1'b0;
      stat_spie_q <= 1'b0;
      stat_spp_q  <= 1'b0;
      stat_sum_q  <= 1'b0;
      stat_mxr_q  <= 1'b0;
    end else if (w_trap) begin
      stat_spp_q  <= current_mode_i[0];
      stat_spie_q <= stat_sie_q;
      stat_sie_q  <= 1'b0;
    end else if (w_sret_do) begin
      stat_sie_q  <= stat_spie_q;
      stat_spie_q <= 1'b1;
      stat_spp_q  <= 1'b0;
    end else if (w_commit && (csr_addr_i == c_CSR_SSTATUS)) begin
      stat_sie_q  <= w_new[1];
      stat_spie_q <= w_new[5];
      stat_spp_q  <= w_new[8];
      stat_sum_q  <= w_new[18];
      stat_mxr_q  <= w_new[19];
    end
  end

  // Remaining S CSRs: trap entry captures sepc/scause/stval, else software writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sie_q        <= '0;
      ssip_q       <= 1'b0;
      stvec_base_q <= RESET_STVEC[c_DW-1:2];
      stvec_mode_q <= RESET_STVEC[1:0];
      sscratch_q   <= '0;
      sepc_q       <= '0;
      scause_q     <= '0;
      stval_q      <= '0;
      satp_q       <= '0;
    end else if (w_trap) begin
      sepc_q   <= exception_pc_i & ~c_ONE;
      scause_q <= w_trap_cause;
      stval_q  <= w_trap_irq ? '0 : exception_tval_i;
    end else if (w_commit) begin
      case (csr_addr_i)
        c_CSR_SIE:      sie_q <= {w_new[9], w_new[5], w_new[1]};
        c_CSR_SIP:      ssip_q <= w_new[1];
        c_CSR_STVEC: begin
          stvec_base_q <= w_new[c_DW-1:2];
          // Reserved MODE encodings leave the previous MODE in place
          if (!w_new[1]) stvec_mode_q <= w_new[1:0];
        end
        c_CSR_SSCRATCH: sscratch_q <= w_new;
        c_CSR_SEPC:     sepc_q <= w_new & ~c_ONE;
        c_CSR_SCAUSE:   scause_q <= w_new;
        c_CSR_STVAL:    stval_q <= w_new;
        c_CSR_SATP:     if (w_satp_legal) satp_q <= w_satp_new;
        default: ;
      endcase
    end
  end

  // Registered trap notification and handler address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_taken_q <= 1'b0;
      trap_pc_q    <= '0;
    end else begin
      trap_taken_q <= w_trap;
      if (w_trap) begin
        if (w_trap_irq && (stvec_mode_q == 2'b01))
          trap_pc_q <= {stvec_base_q, 2'b00} + {{(c_DW-6){1'b0}}, w_trap_code, 2'b00};
        else
          trap_pc_q <= {stvec_base_q, 2'b00};
      end
    end
  end

  assign sfence_ready_o = sfence_valid_i & ~w_busy & ~w_flush_satp;

  // Flush FSM next state: satp-induced flushes win over a same-cycle SFENCE
  always_comb begin
    state_d      = state_q;
    flush_all_d  = flush_all_q;
    flush_asid_d = flush_asid_q;
    if (state_q == c_ST_IDLE) begin
      if (w_flush_satp) begin
        state_d      = c_ST_BUSY;
        flush_all_d  = w_mode_chg;
        flush_asid_d = satp_q[c_ASID_LSB +: ASID_WIDTH];
      end else if (sfence_ready_o) begin
        state_d      = c_ST_BUSY;
        flush_all_d  = sfence_all_i;
        flush_asid_d = sfence_asid_i;
      end
    end else if (tlb_flush_ack_i) begin
      state_d = c_ST_IDLE;
    end
  end

  // Flush FSM state and held request attributes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= c_ST_IDLE;
      flush_all_q  <= 1'b0;
      flush_asid_q <= '0;
    end else begin
      state_q      <= state_d;
      flush_all_q  <= flush_all_d;
      flush_asid_q <= flush_asid_d;
    end
  end

  assign tlb_flush_req_o  = w_busy;
  assign tlb_flush_all_o  = flush_all_q;
  assign tlb_flush_asid_o = flush_asid_q;
  assign trap_taken_o     = trap_taken_q;
  assign trap_pc_o        = trap_pc_q;
  assign return_pc_o      = sepc_q;
  assign return_mode_o    = {1'b0, stat_spp_q};
  assign satp_o           = satp_q;
  assign sum_o            = stat_sum_q;
  assign mxr_o            = stat_mxr_q;

endmodule
`default_nettype wire

// File: tb/tb_supervisor_trap_csr.sv
`default_nettype none
// ============================================================================
// Module      : tb_supervisor_trap_csr
// Description : Directed self-checking bench for supervisor_trap_csr (RV64
//               instance plus an RV32 instance for the Sv32 SATP layout).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_supervisor_trap_csr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // RV64 instance signals
  logic        rst_n, csr_valid, csr_ready, csr_error;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op, mode, return_mode;
  logic [63:0] csr_wdata, csr_rdata, exc_pc, exc_tval, trap_pc, return_pc, satp;
  logic        stip, seip, exc, irq_take, sret, irq_pending, trap_taken, sum, mxr;
  logic [3:0]  exc_code, irq_code;
  logic        sfence_valid, sfence_all, sfence_ready, req, fall, ack;
  logic [15:0] sfence_asid, fasid;

  // RV32 instance signals
  logic        b_rst_n, b_valid, b_ready, b_error, b_irq_pending, b_trap_taken;
  logic [11:0] b_addr;
  logic [1:0]  b_op, b_mode, b_return_mode;
  logic [31:0] b_wdata, b_rdata, b_trap_pc, b_return_pc, b_satp;
  logic [3:0]  b_irq_code;
  logic        b_sum, b_mxr, b_sfence_ready, b_req, b_all;
  logic [8:0]  b_asid;

  int tests = 0;
  int fails = 0;

  supervisor_trap_csr #(.DATA_WIDTH(64), .ASID_WIDTH(16), .RESET_STVEC('0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .csr_valid_i(csr_valid), .csr_addr_i(csr_addr), .csr_op_i(csr_op), .csr_wdata_i(csr_wdata),
    .csr_ready_o(csr_ready), .csr_rdata_o(csr_rdata), .csr_error_o(csr_error),
    .current_mode_i(mode), .stip_i(stip), .seip_i(seip),
    .exception_i(exc), .exception_code_i(exc_code), .exception_pc_i(exc_pc),
    .exception_tval_i(exc_tval), .irq_take_i(irq_take), .sret_i(sret),
    .irq_pending_o(irq_pending), .irq_code_o(irq_code), .trap_taken_o(trap_taken),
    .trap_pc_o(trap_pc), .return_pc_o(return_pc), .return_mode_o(return_mode),
    .satp_o(satp), .sum_o(sum), .mxr_o(mxr),
    .sfence_valid_i(sfence_valid), .sfence_all_i(sfence_all), .sfence_asid_i(sfence_asid),
    .sfence_ready_o(sfence_ready), .tlb_flush_req_o(req), .tlb_flush_all_o(fall),
    .tlb_flush_asid_o(fasid), .tlb_flush_ack_i(ack)
  );

  supervisor_trap_csr #(.DATA_WIDTH(32), .ASID_WIDTH(9), .RESET_STVEC('0)) u_dut32 (
    .clk(clk), .rst_n(b_rst_n),
    .csr_valid_i(b_valid), .csr_addr_i(b_addr), .csr_op_i(b_op), .csr_wdata_i(b_wdata),
    .csr_ready_o(b_ready), .csr_rdata_o(b_rdata), .csr_error_o(b_error),
    .current_mode_i(b_mode), .stip_i(1'b0), .seip_i(1'b0),
    .exception_i(1'b0), .exception_code_i(4'h0), .exception_pc_i(32'h0),
    .exception_tval_i(32'h0), .irq_take_i(1'b0), .sret_i(1'b0),
    .irq_pending_o(b_irq_pending), .irq_code_o(b_irq_code), .trap_taken_o(b_trap_taken),
    .trap_pc_o(b_trap_pc), .return_pc_o(b_return_pc), .return_mode_o(b_return_mode),
    .satp_o(b_satp), .sum_o(b_sum), .mxr_o(b_mxr),
    .sfence_valid_i(1'b0), .sfence_all_i(1'b0), .sfence_asid_i(9'h0),
    .sfence_ready_o(b_sfence_ready), .tlb_flush_req_o(b_req), .tlb_flush_all_o(b_all),
    .tlb_flush_asid_o(b_asid), .tlb_flush_ack_i(1'b0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic csr_set(input logic [1:0] op, input logic [11:0] a, input logic [63:0] d);
    csr_valid = 1'b1; csr_op = op; csr_addr = a; csr_wdata = d;
    #1;
  endtask

  task automatic csr_off;
    csr_valid = 1'b0; csr_op = 2'b00;
    #1;
  endtask

  task automatic csr_wr(input logic [1:0] op, input logic [11:0] a, input logic [63:0] d);
    csr_set(op, a, d);
    tick;
    csr_off;
  endtask

  task automatic csr_rd(input string tag, input logic [11:0] a, input logic [63:0] exp);
    csr_set(2'b00, a, 64'h0);
    check(tag, csr_rdata, exp);
    csr_off;
  endtask

  task automatic ack_pulse;
    ack = 1'b1;
    tick;
    ack = 1'b0;
    #1;
  endtask

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 0; b_rst_n = 0;
    csr_valid = 0; csr_addr = '0; csr_op = '0; csr_wdata = '0; mode = 2'b01;
    stip = 0; seip = 0; exc = 0; exc_code = '0; exc_pc = '0; exc_tval = '0;
    irq_take = 0; sret = 0; sfence_valid = 0; sfence_all = 0; sfence_asid = '0; ack = 0;
    b_valid = 0; b_addr = '0; b_op = '0; b_wdata = '0; b_mode = 2'b01;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_satp", satp, 64'h0);
    check("rst_req", {63'h0, req}, 64'h0);
    check("rst_trap_taken", {63'h0, trap_taken}, 64'h0);
    check("rst_irq_pending", {63'h0, irq_pending}, 64'h0);
    check("rst_return_pc", return_pc, 64'h0);
    rst_n = 1; b_rst_n = 1;
    tick;
    csr_rd("rst_stvec", 12'h105, 64'h0);

    // 1: legal satp write with MODE change -> flush all, satp stalls while busy
    csr_set(2'b01, 12'h180, 64'h8000_0000_0000_0123);
    check("satp_wr_ready", {63'h0, csr_ready}, 64'h1);
    tick;
    csr_off;
    check("satp_val", satp, 64'h8000_0000_0000_0123);
    check("flush_req_rise", {63'h0, req}, 64'h1);
    check("flush_all_mode", {63'h0, fall}, 64'h1);
    for (int i = 0; i < 5; i++) begin
      tick;
      check("flush_req_held", {63'h0, req}, 64'h1);
    end
    csr_set(2'b00, 12'h180, 64'h0);
    check("satp_rd_stall", {63'h0, csr_ready}, 64'h0);
    csr_off;
    csr_set(2'b00, 12'h140, 64'h0);
    check("other_rd_no_stall", {63'h0, csr_ready}, 64'h1);
    csr_off;
    sfence_valid = 1; #1;
    check("sfence_ready_busy", {63'h0, sfence_ready}, 64'h0);
    sfence_valid = 0;
    ack_pulse;
    check("flush_req_drop", {63'h0, req}, 64'h0);
    csr_set(2'b00, 12'h180, 64'h0);
    check("satp_rd_ready_idle", {63'h0, csr_ready}, 64'h1);
    check("satp_rd_val", csr_rdata, 64'h8000_0000_0000_0123);
    csr_off;

    // 2: illegal MODE ignored; ASID-only change flushes old ASID; SFENCE path
    csr_wr(2'b01, 12'h180, 64'h5000_0000_0000_0456);
    check("satp_illegal_kept", satp, 64'h8000_0000_0000_0123);
    check("satp_illegal_noflush", {63'h0, req}, 64'h0);
    csr_wr(2'b01, 12'h180, 64'h8000_3000_0000_0123);
    check("satp_asid_val", satp, 64'h8000_3000_0000_0123);
    check("asid_flush_req", {63'h0, req}, 64'h1);
    check("asid_flush_all", {63'h0, fall}, 64'h0);
    check("asid_flush_old", {48'h0, fasid}, 64'h0);
    ack_pulse;
    sfence_valid = 1; sfence_all = 0; sfence_asid = 16'h0055; #1;
    check("sfence_ready_idle", {63'h0, sfence_ready}, 64'h1);
    tick;
    sfence_valid = 0; #1;
    check("sfence_req", {63'h0, req}, 64'h1);
    check("sfence_asid", {48'h0, fasid}, 64'h55);
    check("sfence_all", {63'h0, fall}, 64'h0);
    ack_pulse;
    check("sfence_req_drop", {63'h0, req}, 64'h0);

    // 3: vectored interrupt entry with SEI priority
    csr_wr(2'b01, 12'h105, 64'h8000_0001);
    csr_wr(2'b01, 12'h104, 64'h222);
    csr_wr(2'b10, 12'h100, 64'h2);
    seip = 1; stip = 1; #1;
    check("irq_pending", {63'h0, irq_pending}, 64'h1);
    check("irq_code_sei", {60'h0, irq_code}, 64'h9);
    exc_pc = 64'h2000; irq_take = 1;
    tick;
    irq_take = 0; #1;
    check("irq_trap_taken", {63'h0, trap_taken}, 64'h1);
    check("irq_trap_pc", trap_pc, 64'h8000_0024);
    csr_rd("irq_scause", 12'h142, 64'h8000_0000_0000_0009);
    csr_rd("irq_stval", 12'h143, 64'h0);
    csr_rd("irq_sstatus", 12'h100, 64'h120);
    csr_rd("irq_sepc", 12'h141, 64'h2000);
    tick;
    check("trap_taken_pulse", {63'h0, trap_taken}, 64'h0);
    check("irq_masked_sie0", {63'h0, irq_pending}, 64'h0);
    csr_wr(2'b10, 12'h144, 64'h2);
    mode = 2'b00; seip = 0; #1;
    check("irq_code_ssi", {60'h0, irq_code}, 64'h1);
    check("irq_pending_umode", {63'h0, irq_pending}, 64'h1);
    seip = 1; #1;
    check("irq_code_sei2", {60'h0, irq_code}, 64'h9);
    mode = 2'b01; seip = 0; stip = 0; #1;
    csr_rd("sip_ssip", 12'h144, 64'h2);
    csr_wr(2'b11, 12'h144, 64'h2);
    csr_rd("sip_clr", 12'h144, 64'h0);

    // 4: exception beats irq_take; non-vectored handler
    exc = 1; exc_code = 4'd2; exc_pc = 64'h1003; exc_tval = 64'hDEAD; irq_take = 1;
    csr_set(2'b00, 12'h140, 64'h0);
    check("exc_stall", {63'h0, csr_ready}, 64'h0);
    tick;
    exc = 0; irq_take = 0;
    csr_off;
    check("exc_trap_taken", {63'h0, trap_taken}, 64'h1);
    check("exc_trap_pc", trap_pc, 64'h8000_0000);
    csr_rd("exc_sepc", 12'h141, 64'h1002);
    csr_rd("exc_scause", 12'h142, 64'h2);
    csr_rd("exc_stval", 12'h143, 64'hDEAD);

    // 5: U-mode access error, WARL masks, SRET
    csr_wr(2'b01, 12'h140, 64'h1234);
    mode = 2'b00;
    csr_set(2'b01, 12'h140, 64'hFFFF);
    check("umode_error", {63'h0, csr_error}, 64'h1);
    check("umode_rdata", csr_rdata, 64'h0);
    check("umode_ready", {63'h0, csr_ready}, 64'h1);
    tick;
    csr_off;
    mode = 2'b01;
    csr_rd("sscratch_kept", 12'h140, 64'h1234);
    csr_set(2'b00, 12'h7FF, 64'h0);
    check("unknown_error", {63'h0, csr_error}, 64'h1);
    csr_off;
    csr_wr(2'b01, 12'h100, 64'hFFFF_FFFF_FFFF_FFFF);
    csr_rd("sstatus_warl", 12'h100, 64'hC0122);
    check("sum_out", {63'h0, sum}, 64'h1);
    check("mxr_out", {63'h0, mxr}, 64'h1);
    csr_wr(2'b01, 12'h104, 64'hFFFF);
    csr_rd("sie_warl", 12'h104, 64'h222);
    csr_wr(2'b01, 12'h105, 64'h3000_0002);
    csr_rd("stvec_mode_keep", 12'h105, 64'h3000_0001);
    csr_wr(2'b01, 12'h141, 64'h777);
    csr_rd("sepc_bit0", 12'h141, 64'h776);
    csr_wr(2'b01, 12'h100, 64'h120);
    check("return_mode_s", {62'h0, return_mode}, 64'h1);
    check("return_pc", return_pc, 64'h776);
    sret = 1;
    tick;
    sret = 0; #1;
    csr_rd("sret_sstatus", 12'h100, 64'h22);
    check("return_mode_u", {62'h0, return_mode}, 64'h0);
    csr_wr(2'b01, 12'h100, 64'h100);
    mode = 2'b00; sret = 1;
    tick;
    sret = 0; mode = 2'b01; #1;
    csr_rd("sret_umode_ignored", 12'h100, 64'h100);

    // 6: RV32 / Sv32 satp and asynchronous reset mid-flush
    b_valid = 1; b_op = 2'b01; b_addr = 12'h180; b_wdata = 32'hFFFF_FFFF;
    tick;
    b_op = 2'b00; #1;
    check("rv32_satp_rd", {32'h0, b_rdata}, 64'hFFFF_FFFF);
    b_valid = 0; #1;
    check("rv32_flush_req", {63'h0, b_req}, 64'h1);
    check("rv32_flush_all", {63'h0, b_all}, 64'h1);
    b_rst_n = 0; #1;
    check("rv32_rst_req", {63'h0, b_req}, 64'h0);
    check("rv32_rst_satp", {32'h0, b_satp}, 64'h0);
    tick;
    b_rst_n = 1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
